// File: rtl/uart_tx_fifo_ctrl_if.sv
// Purpose : bundles the producer write port, FIFO status and the transmitter
//           start/done handshake of uart_tx_fifo_ctrl into one connection.
// Latency : n/a (wires only).
// Backpr. : producer watches full/overflow; transmitter side paced by done tick.
// Ports   : i_wr/i_wr_data (push), o_full/o_empty/o_count/o_overflow (status),
//           o_tx_start/o_tx_data/i_tx_done_tick/o_busy (transmitter handshake).
interface uart_tx_fifo_ctrl_if #(
   parameter int DBIT   = 8,
   parameter int ADDR_W = 4
);
   // producer side
   logic              i_wr;
   logic [DBIT-1:0]   i_wr_data;
   logic              o_full;
   logic              o_empty;
   logic [ADDR_W:0]   o_count;
   logic              o_overflow;
   // transmitter side
   logic              o_tx_start;
   logic [DBIT-1:0]   o_tx_data;
   logic              i_tx_done_tick;
   logic              o_busy;

   // master: the environment (producer + transmitter) driving the block
   modport master (
      output i_wr, i_wr_data, i_tx_done_tick,
      input  o_full, o_empty, o_count, o_overflow,
      input  o_tx_start, o_tx_data, o_busy
   );

   // slave: the FIFO controller itself
   modport slave (
      input  i_wr, i_wr_data, i_tx_done_tick,
      output o_full, o_empty, o_count, o_overflow,
      output o_tx_start, o_tx_data, o_busy
   );
endinterface

// File: rtl/uart_tx_fifo_ctrl.sv
// Purpose : queues producer bytes in a 2**ADDR_W FIFO and launches them one at a
//           time into the UART transmitter using its start / done-tick handshake.
// Latency : write into empty FIFO at edge N -> o_tx_start high after edge N+1.
// Backpr. : writes while full are dropped with a one-cycle o_overflow pulse;
//           no new start is issued until the transmitter's done tick is seen.
// Ports   : i_clock, i_reset (sync, active-high), bus (uart_tx_fifo_ctrl_if.slave).
module uart_tx_fifo_ctrl #(
   parameter int DBIT   = 8,
   parameter int ADDR_W = 4
) (
   input  logic                  i_clock,
   input  logic                  i_reset,
   uart_tx_fifo_ctrl_if.slave    bus
);

   localparam int DEPTH = 1 << ADDR_W;

   typedef enum logic {
      IDLE      = 1'b0,
      WAIT_DONE = 1'b1
   } state_t;

   // ------------------------------------------------------------------
   // storage and bookkeeping
   // ------------------------------------------------------------------
   logic [DBIT-1:0]   mem [DEPTH];
   logic [ADDR_W-1:0] wr_ptr;
   logic [ADDR_W-1:0] rd_ptr;
   logic [ADDR_W:0]   count;

   state_t            state;
   state_t            state_nxt;

   logic              full;
   logic              empty;
   logic              push;
   logic              pop;

   logic              tx_start;
   logic              tx_start_nxt;
   logic [DBIT-1:0]   tx_data;
   logic              busy;
   logic              busy_nxt;
   logic              overflow;

   // Full/empty are pure decodes of the registered count, so they describe
   // the occupancy at the start of the cycle. A launch in the same cycle
   // therefore cannot make room for a write that arrives while full.
   assign full  = (count == {1'b1, {ADDR_W{1'b0}}});
   assign empty = (count == '0);
   assign push  = bus.i_wr && !full;

   // ------------------------------------------------------------------
   // launch FSM: next-state / launch decision
   // ------------------------------------------------------------------
   always_comb begin
      state_nxt    = state;
      pop          = 1'b0;
      tx_start_nxt = 1'b0;
      busy_nxt     = busy;
      unique case (state)
         IDLE: begin
            // done ticks arriving here are stale and deliberately ignored
            if (!empty) begin
               pop          = 1'b1;
               tx_start_nxt = 1'b1;
               busy_nxt     = 1'b1;
               state_nxt    = WAIT_DONE;
            end
         end
         WAIT_DONE: begin
            if (bus.i_tx_done_tick) begin
               busy_nxt  = 1'b0;
               state_nxt = IDLE;
            end
         end
         default: begin
            state_nxt = IDLE;
            busy_nxt  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // ------------------------------------------------------------------
   // FIFO memory: no reset, contents are only ever read after a write
   // ------------------------------------------------------------------
   always_ff @(posedge i_clock) begin
      if (push && !i_reset) begin
         mem[wr_ptr] <= bus.i_wr_data;
      end
   end

   // ------------------------------------------------------------------
   // pointers, occupancy and registered outputs
   // ------------------------------------------------------------------
   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         tx_start <= 1'b0;
         tx_data  <= '0;
         busy     <= 1'b0;
         overflow <= 1'b0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + ADDR_W'(1);
         end
         if (pop) begin
            rd_ptr  <= rd_ptr + ADDR_W'(1);
            // tx_data is only loaded on a launch, so it stays stable for the
            // whole frame and beyond, until the next launch
            tx_data <= mem[rd_ptr];
         end
         // coincident push and pop leave the occupancy untouched
         unique case ({push, pop})
            2'b10:   count <= count + (ADDR_W+1)'(1);
            2'b01:   count <= count - (ADDR_W+1)'(1);
            default: count <= count;
         endcase
         tx_start <= tx_start_nxt;
         busy     <= busy_nxt;
         overflow <= bus.i_wr && full;
      end
   end

   assign bus.o_full     = full;
   assign bus.o_empty    = empty;
   assign bus.o_count    = count;
   assign bus.o_overflow = overflow;
   assign bus.o_tx_start = tx_start;
   assign bus.o_tx_data  = tx_data;
   assign bus.o_busy     = busy;

   // ------------------------------------------------------------------
   // structural invariants
   // ------------------------------------------------------------------
   // occupancy can never exceed the physical depth
   a_count_range: assert property (@(posedge i_clock) disable iff (i_reset)
      count <= (ADDR_W+1)'(DEPTH));

   // a start pulse always coincides with a frame marked in flight
   a_start_busy: assert property (@(posedge i_clock) disable iff (i_reset)
      tx_start |-> busy);

   // busy mirrors the WAIT_DONE state exactly
   a_busy_state: assert property (@(posedge i_clock) disable iff (i_reset)
      busy == (state == WAIT_DONE));

endmodule

// File: tb/tb_uart_tx_fifo_ctrl.sv
// Purpose : randomized self-checking bench for uart_tx_fifo_ctrl against a
//           queue-based model of the FIFO and the in-flight frame.
// Latency : n/a. Backpressure : transmitter done ticks are bench-generated.
module tb_uart_tx_fifo_ctrl;
   localparam int DBIT   = 8;
   localparam int ADDR_W = 4;
   localparam int DEPTH  = 16;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   uart_tx_fifo_ctrl_if #(.DBIT(DBIT), .ADDR_W(ADDR_W)) bus ();

   uart_tx_fifo_ctrl #(.DBIT(DBIT), .ADDR_W(ADDR_W)) dut (
      .i_clock (clk),
      .i_reset (rst),
      .bus     (bus)
   );

   int checks = 0;
   int errors = 0;

   // reference model: queue of waiting bytes plus one in-flight flag
   logic [7:0] m_q[$];
   logic       m_busy, m_start, m_ovf;
   logic [7:0] m_data;
   logic [7:0] acc_log[$];
   logic [7:0] obs_log[$];

   // drive one cycle of stimulus, advance the model at the edge, settle at negedge
   task automatic cycle(input logic wr, input logic [7:0] d, input logic done, input logic r);
      logic launch;
      bus.i_wr = wr; bus.i_wr_data = d; bus.i_tx_done_tick = done; rst = r;
      @(posedge clk);
      if (r) begin
         m_q.delete(); m_busy = 0; m_start = 0; m_data = 0; m_ovf = 0;
      end else begin
         launch  = !m_busy && (m_q.size() > 0);
         m_ovf   = wr && (m_q.size() == DEPTH);
         m_start = launch;
         if (launch) begin
            m_data = m_q.pop_front();
            m_busy = 1;
         end else if (m_busy && done) begin
            m_busy = 0;
         end
         if (wr && !m_ovf) begin
            m_q.push_back(d);
            acc_log.push_back(d);
         end
      end
      @(negedge clk);
      if (bus.o_tx_start === 1'b1) obs_log.push_back(bus.o_tx_data);
      bus.i_wr = 0; bus.i_tx_done_tick = 0; rst = 0;
   endtask

   task automatic test_reset();
      for (int i = 0; i < 4; i++) cycle(1'b1, 8'($urandom), 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) cycle(1'b1, 8'($urandom), 1'b0, 1'b1);
      checks++; if (bus.o_empty !== 1'b1) begin errors++; $display("FAIL reset_empty got %b want 1", bus.o_empty); end
      checks++; if (bus.o_full !== 1'b0) begin errors++; $display("FAIL reset_full got %b want 0", bus.o_full); end
      checks++; if (bus.o_count !== 5'd0) begin errors++; $display("FAIL reset_count got %0d want 0", bus.o_count); end
      checks++; if (bus.o_tx_start !== 1'b0) begin errors++; $display("FAIL reset_start got %b want 0", bus.o_tx_start); end
      checks++; if (bus.o_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", bus.o_busy); end
      checks++; if (bus.o_overflow !== 1'b0) begin errors++; $display("FAIL reset_ovf got %b want 0", bus.o_overflow); end
      checks++; if (bus.o_tx_data !== 8'h00) begin errors++; $display("FAIL reset_data got %h want 00", bus.o_tx_data); end
      // writes held during reset must not have been stored
      for (int i = 0; i < 4; i++) begin
         cycle(1'b0, 8'h00, 1'b0, 1'b0);
         checks++; if (bus.o_count !== 5'd0 || bus.o_tx_start !== 1'b0) begin
            errors++; $display("FAIL reset_nostore count %0d start %b want 0 0", bus.o_count, bus.o_tx_start);
         end
      end
   endtask

   task automatic test_single_byte();
      cycle(1'b1, 8'hA5, 1'b0, 1'b0);
      checks++; if (bus.o_count !== 5'd1) begin errors++; $display("FAIL single_count1 got %0d want 1", bus.o_count); end
      checks++; if (bus.o_tx_start !== 1'b0) begin errors++; $display("FAIL single_early_start got %b want 0", bus.o_tx_start); end
      cycle(1'b0, 8'h00, 1'b0, 1'b0);
      checks++; if (bus.o_tx_start !== 1'b1) begin errors++; $display("FAIL single_start got %b want 1", bus.o_tx_start); end
      checks++; if (bus.o_tx_data !== 8'hA5) begin errors++; $display("FAIL single_data got %h want a5", bus.o_tx_data); end
      checks++; if (bus.o_busy !== 1'b1) begin errors++; $display("FAIL single_busy got %b want 1", bus.o_busy); end
      checks++; if (bus.o_count !== 5'd0) begin errors++; $display("FAIL single_count0 got %0d want 0", bus.o_count); end
      for (int i = 0; i < 6; i++) begin
         cycle(1'b0, 8'h00, 1'b0, 1'b0);
         checks++; if (bus.o_tx_start !== 1'b0 || bus.o_busy !== 1'b1 || bus.o_tx_data !== 8'hA5) begin
            errors++; $display("FAIL single_hold start %b busy %b data %h want 0 1 a5", bus.o_tx_start, bus.o_busy, bus.o_tx_data);
         end
      end
      cycle(1'b0, 8'h00, 1'b1, 1'b0);
      checks++; if (bus.o_busy !== 1'b0) begin errors++; $display("FAIL single_done_busy got %b want 0", bus.o_busy); end
      cycle(1'b0, 8'h00, 1'b0, 1'b0);
      checks++; if (bus.o_tx_start !== 1'b0) begin errors++; $display("FAIL single_no_repeat got %b want 0", bus.o_tx_start); end
   endtask

   task automatic test_burst();
      int   dly;
      logic prev_busy, expect_start;
      cycle(1'b0, 8'h00, 1'b0, 1'b1);
      obs_log.delete(); acc_log.delete();
      dly = 0; expect_start = 0;
      for (int c = 0; c < 300 && !(c >= 3 && obs_log.size() == 3 && !m_busy); c++) begin
         logic done;
         done = 0;
         if (bus.o_busy === 1'b1 && dly == 0) done = 1;
         else if (dly > 0) dly--;
         prev_busy = bus.o_busy;
         cycle(c < 3, 8'(c + 1), done, 1'b0);
         if (bus.o_tx_start === 1'b1) dly = $urandom_range(3, 8);
         checks++; if (bus.o_tx_start !== m_start || bus.o_busy !== m_busy || bus.o_count !== 5'(m_q.size()) || bus.o_tx_data !== m_data) begin
            errors++; $display("FAIL burst_model start %b busy %b count %0d data %h want %b %b %0d %h",
               bus.o_tx_start, bus.o_busy, bus.o_count, bus.o_tx_data, m_start, m_busy, m_q.size(), m_data);
         end
         if (bus.o_tx_start === 1'b1 && prev_busy === 1'b1) begin
            checks++; errors++; $display("FAIL burst_start_while_busy got 1 want 0");
         end
         if (expect_start) begin
            checks++; if (bus.o_tx_start !== 1'b1) begin errors++; $display("FAIL burst_gap start %b want 1 two cycles after done", bus.o_tx_start); end
         end
         expect_start = done && (bus.o_count !== 5'd0);
      end
      checks++; if (obs_log.size() != 3) begin errors++; $display("FAIL burst_frames got %0d want 3", obs_log.size()); end
      for (int i = 0; i < 3 && i < obs_log.size(); i++) begin
         checks++; if (obs_log[i] !== 8'(i + 1)) begin errors++; $display("FAIL burst_order[%0d] got %h want %h", i, obs_log[i], 8'(i + 1)); end
      end
   endtask

   task automatic test_full_overflow();
      cycle(1'b0, 8'h00, 1'b0, 1'b1);
      obs_log.delete(); acc_log.delete();
      for (int i = 0; i < 18; i++) begin
         cycle(1'b1, 8'(i), 1'b0, 1'b0);
         checks++; if (bus.o_count !== 5'(m_q.size()) || bus.o_overflow !== m_ovf) begin
            errors++; $display("FAIL fill[%0d] count %0d ovf %b want %0d %b", i, bus.o_count, bus.o_overflow, m_q.size(), m_ovf);
         end
         if (i == 16) begin
            checks++; if (bus.o_full !== 1'b1 || bus.o_count !== 5'd16) begin
               errors++; $display("FAIL fill_full full %b count %0d want 1 16", bus.o_full, bus.o_count);
            end
         end
         if (i == 17) begin
            checks++; if (bus.o_overflow !== 1'b1) begin errors++; $display("FAIL ovf_pulse got %b want 1", bus.o_overflow); end
         end else begin
            checks++; if (bus.o_overflow !== 1'b0) begin errors++; $display("FAIL ovf_early[%0d] got %b want 0", i, bus.o_overflow); end
         end
      end
      cycle(1'b0, 8'h00, 1'b0, 1'b0);
      checks++; if (bus.o_overflow !== 1'b0) begin errors++; $display("FAIL ovf_one_cycle got %b want 0", bus.o_overflow); end
      for (int c = 0; c < 200 && !(obs_log.size() == 17 && !m_busy); c++) begin
         cycle(1'b0, 8'h00, bus.o_busy, 1'b0);
         checks++; if (bus.o_count !== 5'(m_q.size()) || bus.o_busy !== m_busy || bus.o_tx_data !== m_data) begin
            errors++; $display("FAIL drain count %0d busy %b data %h want %0d %b %h", bus.o_count, bus.o_busy, bus.o_tx_data, m_q.size(), m_busy, m_data);
         end
      end
      checks++; if (obs_log.size() != 17) begin errors++; $display("FAIL ovf_frames got %0d want 17", obs_log.size()); end
      for (int i = 0; i < obs_log.size(); i++) begin
         checks++; if (obs_log[i] !== 8'(i)) begin errors++; $display("FAIL ovf_order[%0d] got %h want %h", i, obs_log[i], 8'(i)); end
      end
   endtask

   task automatic test_wrap_push_pop();
      int         sent_w, coincident;
      logic       launch_pred, wr;
      logic [4:0] prev_cnt;
      cycle(1'b0, 8'h00, 1'b0, 1'b1);
      obs_log.delete(); acc_log.delete();
      sent_w = 0; coincident = 0;
      for (int c = 0; c < 2000 && !(sent_w == 40 && m_q.size() == 0 && !m_busy); c++) begin
         launch_pred = !m_busy && (m_q.size() > 0);
         wr = (sent_w < 40) && (m_q.size() < DEPTH) && (launch_pred || ($urandom_range(0, 3) == 0));
         prev_cnt = bus.o_count;
         cycle(wr, 8'($urandom), 1'($urandom_range(0, 1)), 1'b0);
         if (wr) sent_w++;
         if (wr && launch_pred) begin
            coincident++;
            checks++; if (bus.o_count !== prev_cnt) begin errors++; $display("FAIL wrap_coincident_count got %0d want %0d", bus.o_count, prev_cnt); end
         end
         checks++; if (bus.o_tx_start !== m_start || bus.o_busy !== m_busy || bus.o_count !== 5'(m_q.size()) || bus.o_tx_data !== m_data) begin
            errors++; $display("FAIL wrap_model start %b busy %b count %0d data %h want %b %b %0d %h",
               bus.o_tx_start, bus.o_busy, bus.o_count, bus.o_tx_data, m_start, m_busy, m_q.size(), m_data);
         end
      end
      checks++; if (coincident < 2) begin errors++; $display("FAIL wrap_coincident_seen got %0d want >=2", coincident); end
      checks++; if (obs_log.size() != 40) begin errors++; $display("FAIL wrap_frames got %0d want 40", obs_log.size()); end
      for (int i = 0; i < obs_log.size() && i < acc_log.size(); i++) begin
         checks++; if (obs_log[i] !== acc_log[i]) begin errors++; $display("FAIL wrap_order[%0d] got %h want %h", i, obs_log[i], acc_log[i]); end
      end
   endtask

   task automatic test_reset_mid();
      cycle(1'b0, 8'h00, 1'b0, 1'b1);
      for (int i = 0; i < 6; i++) cycle(1'b1, 8'($urandom), 1'b0, 1'b0);
      checks++; if (bus.o_busy !== 1'b1 || bus.o_count !== 5'd5) begin
         errors++; $display("FAIL mid_setup busy %b count %0d want 1 5", bus.o_busy, bus.o_count);
      end
      cycle(1'b0, 8'h00, 1'b0, 1'b1);
      checks++; if (bus.o_busy !== 1'b0 || bus.o_count !== 5'd0 || bus.o_empty !== 1'b1 || bus.o_full !== 1'b0 ||
                    bus.o_tx_start !== 1'b0 || bus.o_tx_data !== 8'h00 || bus.o_overflow !== 1'b0) begin
         errors++; $display("FAIL mid_reset busy %b count %0d empty %b full %b start %b data %h ovf %b want 0 0 1 0 0 00 0",
            bus.o_busy, bus.o_count, bus.o_empty, bus.o_full, bus.o_tx_start, bus.o_tx_data, bus.o_overflow);
      end
      cycle(1'b1, 8'h3C, 1'b0, 1'b0);
      cycle(1'b0, 8'h00, 1'b0, 1'b0);
      checks++; if (bus.o_tx_start !== 1'b1 || bus.o_tx_data !== 8'h3C) begin
         errors++; $display("FAIL mid_relaunch start %b data %h want 1 3c", bus.o_tx_start, bus.o_tx_data);
      end
      cycle(1'b0, 8'h00, 1'b1, 1'b0);
      cycle(1'b0, 8'h00, 1'b0, 1'b0);
      checks++; if (bus.o_busy !== 1'b0 || bus.o_count !== 5'd0 || bus.o_tx_start !== 1'b0) begin
         errors++; $display("FAIL mid_after busy %b count %0d start %b want 0 0 0", bus.o_busy, bus.o_count, bus.o_tx_start);
      end
   endtask

   initial begin
      rst = 1'b1;
      bus.i_wr = 1'b0; bus.i_wr_data = '0; bus.i_tx_done_tick = 1'b0;
      m_busy = 0; m_start = 0; m_ovf = 0; m_data = 0;
      @(negedge clk);
      cycle(1'b0, 8'h00, 1'b0, 1'b1);
      cycle(1'b0, 8'h00, 1'b0, 1'b1);
      test_reset();
      test_single_byte();
      test_burst();
      test_full_overflow();
      test_wrap_push_pop();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
